// File: rtl/sigma_delta_modulator.sv
// Second-order 1-bit sigma-delta modulator with integrator saturation,
// optional LSB dither and automatic recovery from integrator runaway.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   reset_n    - asynchronous active-low reset
//   din        - signed sample from the inverse-sinc filter
//   din_valid  - sample strobe (filter ce_out), loads x_hold
//   mod_en     - modulator tick enable
//   clip_clr   - clears the sticky clip flag
//   dout       - pulse-density output, 1 = +FS, 0 = -FS
//   clip_flag  - sticky, set when a recovery happens
//   run        - high while the modulator is in RUN
module sigma_delta_modulator #(
    parameter int DIN_W      = 18,
    parameter int INT_W      = 24,
    parameter int CLIP_LIMIT = 64,
    parameter bit DITHER_EN  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    input  logic             mod_en,
    input  logic             clip_clr,
    output logic             dout,
    output logic             clip_flag,
    output logic             run
);

    // Two guard bits keep every intermediate sum exact before clamping.
    localparam int SUM_W = INT_W + 2;

    localparam logic signed [SUM_W-1:0] FS =
        {{(SUM_W-DIN_W){1'b0}}, 1'b1, {(DIN_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-INT_W+1){1'b0}}, {(INT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-INT_W+1){1'b1}}, {(INT_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] ONE =
        {{(SUM_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RECOVER
    } state_t;

    state_t state_q, state_d;

    logic [DIN_W-1:0] x_hold_q, x_hold_d;
    logic [INT_W-1:0] int1_q, int1_d;
    logic [INT_W-1:0] int2_q, int2_d;
    logic [6:0]       sat_cnt_q, sat_cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             dout_q, dout_d;
    logic             clip_flag_q, clip_flag_d;

    logic signed [SUM_W-1:0] x_ext;
    logic signed [SUM_W-1:0] x_in;
    logic signed [SUM_W-1:0] fb;
    logic signed [SUM_W-1:0] sum1;
    logic signed [SUM_W-1:0] sum2;
    logic [INT_W-1:0]        int1_sat;
    logic [INT_W-1:0]        int2_sat;
    logic                    int2_clamp;
    logic                    lfsr_fb;
    logic                    clip_set;

    function automatic logic [INT_W-1:0] sat(
        input logic signed [SUM_W-1:0] v
    );
        if (v > SAT_MAX) begin
            sat = SAT_MAX[INT_W-1:0];
        end else if (v < SAT_MIN) begin
            sat = SAT_MIN[INT_W-1:0];
        end else begin
            sat = v[INT_W-1:0];
        end
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_hold_q    <= '0;
            int1_q      <= '0;
            int2_q      <= '0;
            sat_cnt_q   <= '0;
            lfsr_q      <= 16'hACE1;
            dout_q      <= 1'b0;
            clip_flag_q <= 1'b0;
        end else begin
            x_hold_q    <= x_hold_d;
            int1_q      <= int1_d;
            int2_q      <= int2_d;
            sat_cnt_q   <= sat_cnt_d;
            lfsr_q      <= lfsr_d;
            dout_q      <= dout_d;
            clip_flag_q <= clip_flag_d;
        end
    end

    // Loop arithmetic
    always_comb begin
        x_ext = {{(SUM_W-DIN_W){x_hold_q[DIN_W-1]}}, x_hold_q};
        if (DITHER_EN) begin
            x_in = x_ext + (lfsr_q[0] ? ONE : -ONE);
        end else begin
            x_in = x_ext;
        end
        fb   = dout_q ? FS : -FS;
        sum1 = {{2{int1_q[INT_W-1]}}, int1_q} + x_in - fb;
        int1_sat = sat(sum1);
        sum2 = {{2{int2_q[INT_W-1]}}, int2_q}
             + {{2{int1_sat[INT_W-1]}}, int1_sat} - fb;
        int2_sat   = sat(sum2);
        int2_clamp = (sum2 > SAT_MAX) || (sum2 < SAT_MIN);
        // Fibonacci taps 16,14,13,11 in right-shift form
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    end

    // Next datapath values
    always_comb begin
        x_hold_d  = din_valid ? din : x_hold_q;
        lfsr_d    = mod_en ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
        int1_d    = int1_q;
        int2_d    = int2_q;
        sat_cnt_d = sat_cnt_q;
        dout_d    = dout_q;
        clip_set  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                int1_d    = '0;
                int2_d    = '0;
                sat_cnt_d = '0;
                if (mod_en) begin
                    dout_d = ~dout_q;
                end
            end
            ST_RUN: begin
                if (mod_en) begin
                    int1_d    = int1_sat;
                    int2_d    = int2_sat;
                    sat_cnt_d = int2_clamp ? sat_cnt_q + 7'd1 : 7'd0;
                    dout_d    = ~int2_sat[INT_W-1];
                end
            end
            ST_RECOVER: begin
                int1_d    = '0;
                int2_d    = '0;
                sat_cnt_d = '0;
                dout_d    = 1'b0;
                clip_set  = 1'b1;
            end
            default: begin
                int1_d = '0;
                int2_d = '0;
            end
        endcase
        // A recovery on the same edge as a clear keeps the flag set
        if (clip_set) begin
            clip_flag_d = 1'b1;
        end else if (clip_clr) begin
            clip_flag_d = 1'b0;
        end else begin
            clip_flag_d = clip_flag_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mod_en && sat_cnt_d == 7'(CLIP_LIMIT)) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        dout      = dout_q;
        clip_flag = clip_flag_q;
        run       = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_sigma_delta_modulator.sv
// Scoreboard bench for sigma_delta_modulator: a behavioural model predicts
// dout/run/clip_flag per clock; a monitor pops and compares after each edge.
module tb_sigma_delta_modulator;

    localparam int      LIMIT = 64;
    localparam longint  FS    = 131072;
    localparam longint  IMAX  = 64'sd8388607;
    localparam longint  IMIN  = -64'sd8388608;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [17:0] din = '0;
    logic        din_valid = 1'b0;
    logic        mod_en = 1'b0;
    logic        clip_clr = 1'b0;
    logic        dout;
    logic        clip_flag;
    logic        run;

    always #5 clk = ~clk;

    sigma_delta_modulator #(
        .DIN_W(18),
        .INT_W(24),
        .CLIP_LIMIT(LIMIT),
        .DITHER_EN(1'b0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .din(din),
        .din_valid(din_valid),
        .mod_en(mod_en),
        .clip_clr(clip_clr),
        .dout(dout),
        .clip_flag(clip_flag),
        .run(run)
    );

    typedef struct packed {
        logic d;
        logic r;
        logic f;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Behavioural model: 0 idle, 1 run, 2 recover
    int     m_st;
    longint m_i1, m_i2, m_x;
    bit     m_d, m_f;
    int     m_cnt;

    int  ones;
    bit  counting = 0;
    bit  ref_bits[$];

    function automatic longint clamp(longint v);
        if (v > IMAX) return IMAX;
        if (v < IMIN) return IMIN;
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_i1 = 0; m_i2 = 0; m_x = 0;
        m_d = 0; m_f = 0; m_cnt = 0;
    endtask

    task automatic model_step(
        input logic [17:0] d, input logic v,
        input logic en, input logic clr
    );
        longint fb, s1, a1, s2, a2;
        int nst;
        bit set_f;
        nst = m_st;
        set_f = 0;
        if (m_st == 0) begin
            if (en) m_d = !m_d;
            if (v) nst = 1;
        end else if (m_st == 1) begin
            if (en) begin
                fb = m_d ? FS : -FS;
                s1 = m_i1 + m_x - fb;
                a1 = clamp(s1);
                s2 = m_i2 + a1 - fb;
                a2 = clamp(s2);
                m_cnt = (a2 != s2) ? m_cnt + 1 : 0;
                m_i1 = a1;
                m_i2 = a2;
                m_d = (a2 >= 0);
                if (m_cnt == LIMIT) nst = 2;
            end
        end else begin
            m_i1 = 0; m_i2 = 0; m_cnt = 0; m_d = 0;
            set_f = 1;
            nst = 1;
        end
        if (set_f) m_f = 1;
        else if (clr) m_f = 0;
        if (v) m_x = longint'($signed(d));
        m_st = nst;
    endtask

    task automatic chk(input string nm, input longint act,
                       input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.d = m_d;
        e.r = (m_st == 1);
        e.f = m_f;
        q.push_back(e);
    endtask

    task automatic cyc(input logic [17:0] d, input logic v,
                       input logic en, input logic clr);
        @(negedge clk);
        reset_n = 1'b1;
        din = d; din_valid = v; mod_en = en; clip_clr = clr;
        model_step(d, v, en, clr);
        push_exp();
        @(posedge clk);
        #1;
        if (en && counting) ones += int'(dout);
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        reset_n = 1'b0;
        din = '0; din_valid = 0; mod_en = 1; clip_clr = 0;
        #1;
        chk("rst_outs", {dout, clip_flag, run}, 0, 0);
        model_reset();
        push_exp();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input logic [17:0] d, input int n);
        for (int i = 0; i < n; i++) cyc(d, 0, 1, 0);
    endtask

    task automatic count_ones(input logic [17:0] d,
                              input string nm, input int lo, input int hi);
        ticks(d, 64);
        ones = 0;
        counting = 1;
        ticks(d, 1024);
        counting = 0;
        chk(nm, ones, lo, hi);
        chk({nm, "_run"}, run, 1, 1);
    endtask

    // Monitor
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if ({dout, run, clip_flag} !== {e.d, e.r, e.f}) begin
                bad++;
                $display("FAIL cyc t=%0t: dout/run/flag got %b%b%b want %b%b%b",
                         $time, dout, run, clip_flag, e.d, e.r, e.f);
            end
        end
    end

    initial begin
        int k;
        model_reset();

        // Reset and idle toggle
        for (int i = 0; i < 5; i++) rst_cycle();
        ticks(18'h0, 8);

        // DC tests
        cyc(18'h0, 1, 1, 0);
        count_ones(18'h0, "dc_zero", 510, 514);
        cyc(18'h10000, 1, 1, 0);
        count_ones(18'h10000, "dc_pos_half", 766, 770);
        chk("dc_pos_flag", clip_flag, 0, 0);
        cyc(18'h30000, 1, 1, 0);
        count_ones(18'h30000, "dc_neg_half", 254, 258);
        chk("dc_neg_flag", clip_flag, 0, 0);

        // Continuous reference run, bits from the model
        for (int i = 0; i < 3; i++) rst_cycle();
        cyc(18'h08000, 1, 0, 0);
        ref_bits.delete();
        for (int i = 0; i < 200; i++) begin
            cyc(18'h08000, 0, 1, 0);
            ref_bits.push_back(m_d);
        end

        // Gapped enable must reproduce the continuous sequence
        for (int i = 0; i < 3; i++) rst_cycle();
        cyc(18'h08000, 1, 0, 0);
        for (int i = 0; i < 200; i++) begin
            cyc(18'h08000, 0, 0, 0);
            cyc(18'h08000, 0, 0, 0);
            cyc(18'h08000, 0, 0, 0);
            cyc(18'h08000, 0, 1, 0);
            total++;
            if (dout !== ref_bits[i]) begin
                bad++;
                $display("FAIL gap_bit %0d: got %b want %b",
                         i, dout, ref_bits[i]);
            end
        end

        // Overdrive and recovery
        for (int i = 0; i < 3; i++) rst_cycle();
        cyc(18'h1FFFF, 1, 1, 0);
        k = 0;
        while (!m_f && k < 2000) begin
            cyc(18'h1FFFF, 0, 1, 0);
            k++;
        end
        chk("od_bound", k, 1, 1999);
        chk("od_flag", clip_flag, 1, 1);
        chk("od_dout", dout, 0, 0);
        cyc(18'h0, 1, 1, 0);
        ticks(18'h0, 50);
        chk("od_flag_hold", clip_flag, 1, 1);
        cyc(18'h0, 0, 1, 1);
        ticks(18'h0, 4);
        chk("od_flag_clr", clip_flag, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(18'($urandom), ($urandom_range(15) == 0),
                1'($urandom), ($urandom_range(31) == 0));
        end

        // Mid-run reset between edges
        cyc(18'h04000, 1, 1, 0);
        ticks(18'h04000, 20);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_dout", dout, 0, 0);
        chk("midrst_run", run, 0, 0);
        model_reset();
        for (int i = 0; i < 3; i++) rst_cycle();
        ticks(18'h0, 8);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", q.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
